// File: rtl/qsn_85b_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qsn_85b_pkg
//  Purpose  : Shared constants, select-bundle type and shift range reduction
//             for the 85-bit quasi-cyclic shift network control logic.
//  Contents : Z        - circulant size (85)
//             SEL_W    - shift factor / left-right select width (7)
//             MERGE_W  - merge select width (Z-1)
//             Z_SEL    - Z expressed at select width
//             qsn_sel_t    - {left_sel, right_sel, merge_sel}
//             reduce_shift - folds a 7-bit factor into 0..Z-1
//  Revision : 1.0 - initial release
// ============================================================================
package qsn_85b_pkg;

  localparam int unsigned Z       = 85;
  localparam int unsigned SEL_W   = 7;
  localparam int unsigned MERGE_W = Z - 1;

  localparam logic [SEL_W-1:0] Z_SEL = SEL_W'(Z);

  typedef struct packed {
    logic [SEL_W-1:0]   left_sel;
    logic [SEL_W-1:0]   right_sel;
    logic [MERGE_W-1:0] merge_sel;
  } qsn_sel_t;

  // A 7-bit factor never exceeds 127 < 2*Z, so a single conditional
  // subtraction is a full modulo-Z reduction.
  function automatic logic [SEL_W-1:0] reduce_shift(input logic [SEL_W-1:0] s);
    return (s < Z_SEL) ? s : (s - Z_SEL);
  endfunction

endpackage : qsn_85b_pkg
`default_nettype wire

// File: rtl/qsn_merge_mask_gen_85b.sv
`default_nettype none
// ============================================================================
//  Module   : qsn_merge_mask_gen_85b
//  Purpose  : Combinational thermometer mask for the QSN merge network.
//             Bit k is set when e != 0 and k >= Z - e, so the upper e
//             positions of the Z-wide word (excluding bit Z-1, which is always
//             fed by the right network) take the left network's output.
//  Ports    : i_e          [SEL_W-1:0]   effective shift, 0..Z-1
//             o_merge_mask [MERGE_W-1:0] 1 selects left_in[k]
//  Revision : 1.0 - initial release
// ============================================================================
module qsn_merge_mask_gen_85b
  import qsn_85b_pkg::*;
(
  input  logic [SEL_W-1:0]   i_e,
  output logic [MERGE_W-1:0] o_merge_mask
);

  // One extra bit keeps Z - e from wrapping for any legal e.
  logic [SEL_W:0] w_thresh;
  logic           w_nonzero;

  assign w_thresh  = {1'b0, Z_SEL} - {1'b0, i_e};
  assign w_nonzero = (i_e != '0);

  genvar k;
  generate
    for (k = 0; k < MERGE_W; k++) begin : g_bit
      assign o_merge_mask[k] = w_nonzero && ((SEL_W+1)'(k) >= w_thresh);
    end
  endgenerate

endmodule : qsn_merge_mask_gen_85b
`default_nettype wire

// File: rtl/qsn_ctrl_85b.sv
`default_nettype none
// ============================================================================
//  Module   : qsn_ctrl_85b
//  Purpose  : Control side of the 85-bit quasi-cyclic shift network. Accepts
//             one shift factor per valid/ready handshake (forward or inverse
//             rotation), registers the left/right/merge selects for the QSN
//             datapath, and flags when the QSN output registers hold data
//             rotated by the previously consumed select set.
//  Ports    : sys_clk        system clock
//             rstn           asynchronous active-low reset
//             shift_in       requested shift factor
//             inv_in         0 = rotate by s, 1 = rotate by (Z-s) mod Z
//             tag_in         user tag carried with the request
//             in_valid       request valid
//             in_ready       request accepted when in_valid && in_ready
//             left_sel       left shift network select
//             right_sel      right shift network select
//             merge_sel      merge network select (1 = left_in[k])
//             sel_valid      select registers hold a request
//             sel_tag        tag of the current select set
//             out_ready      consumer takes the current select set
//             qsn_out_valid  QSN output flops hold the consumed rotation
//             qsn_out_tag    tag matching qsn_out_valid
//             err_range      sticky: a shift_in >= Z was accepted
//  Revision : 1.0 - initial release
// ============================================================================
module qsn_ctrl_85b
  import qsn_85b_pkg::*;
#(
  parameter int unsigned TAG_W = 8
) (
  input  logic               sys_clk,
  input  logic               rstn,
  input  logic [SEL_W-1:0]   shift_in,
  input  logic               inv_in,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [SEL_W-1:0]   left_sel,
  output logic [SEL_W-1:0]   right_sel,
  output logic [MERGE_W-1:0] merge_sel,
  output logic               sel_valid,
  output logic [TAG_W-1:0]   sel_tag,
  input  logic               out_ready,
  output logic               qsn_out_valid,
  output logic [TAG_W-1:0]   qsn_out_tag,
  output logic               err_range
);

  qsn_sel_t           r_sel;
  logic               r_sel_valid;
  logic [TAG_W-1:0]   r_sel_tag;
  logic               r_qsn_out_valid;
  logic [TAG_W-1:0]   r_qsn_out_tag;
  logic               r_err_range;

  logic               w_accept;
  logic               w_consume;
  logic [SEL_W-1:0]   w_sr;
  logic [SEL_W-1:0]   w_e;
  logic [SEL_W-1:0]   w_left;
  logic [MERGE_W-1:0] w_merge;

  // Single register stage: a new request may enter whenever the current
  // set is empty or leaving this cycle.
  assign in_ready  = !r_sel_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_sel_valid && out_ready;

  // Effective shift in 0..Z-1; the inverse of 0 is 0, not Z.
  assign w_sr   = reduce_shift(shift_in);
  assign w_e    = inv_in ? ((w_sr == '0) ? '0 : (Z_SEL - w_sr)) : w_sr;
  assign w_left = (w_e == '0) ? '0 : (Z_SEL - w_e);

  qsn_merge_mask_gen_85b u_merge_mask (
    .i_e          (w_e),
    .o_merge_mask (w_merge)
  );

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_sel           <= '0;
      r_sel_valid     <= 1'b0;
      r_sel_tag       <= '0;
      r_qsn_out_valid <= 1'b0;
      r_qsn_out_tag   <= '0;
      r_err_range     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sel.left_sel  <= w_left;
        r_sel.right_sel <= w_e;
        r_sel.merge_sel <= w_merge;
        r_sel_tag       <= tag_in;
      end

      if (w_accept) begin
        r_sel_valid <= 1'b1;
      end else if (out_ready) begin
        r_sel_valid <= 1'b0;
      end

      if (w_accept && (shift_in >= Z_SEL)) begin
        r_err_range <= 1'b1;
      end

      // Mirrors the QSN's own output flops: the set consumed at this edge
      // is the data those flops hold during the next cycle.
      r_qsn_out_valid <= w_consume;
      if (w_consume) begin
        r_qsn_out_tag <= r_sel_tag;
      end
    end
  end

  assign left_sel      = r_sel.left_sel;
  assign right_sel     = r_sel.right_sel;
  assign merge_sel     = r_sel.merge_sel;
  assign sel_valid     = r_sel_valid;
  assign sel_tag       = r_sel_tag;
  assign qsn_out_valid = r_qsn_out_valid;
  assign qsn_out_tag   = r_qsn_out_tag;
  assign err_range     = r_err_range;

endmodule : qsn_ctrl_85b
`default_nettype wire
